// File: rtl/riscv_pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline sequencing logic.
package riscv_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        REDIRECT   = 2'd2
    } pipe_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [4:0]  REG_X0    = 5'd0;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Combinational load-use comparator: ID source registers against the EX load destination.
module load_use_detect
    import riscv_pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    output logic       load_use_o
);

    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign rd_live    = (ex_rd_i != REG_X0);
    assign rs1_hit    = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit    = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    assign load_use_o = ex_mem_read_i && rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline stall/flush/redirect sequencer for the 5-stage RV32I core.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller
    import riscv_pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_branch_taken_i,
    input  logic        ex_jal_i,
    input  logic        ex_jalr_i,
    input  logic [31:0] ex_target_i,
    input  logic        mem_stall_i,
    output logic        pc_enable_o,
    output logic        if_id_enable_o,
    output logic        id_ex_enable_o,
    output logic        ex_mem_enable_o,
    output logic        mem_wb_enable_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        pc_redirect_o,
    output logic [31:0] pc_redirect_target_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_count_o,
    output logic [31:0] flush_count_o,
    output logic [31:0] freeze_count_o
`endif
);

    localparam logic [CNT_W-1:0] LS_INIT = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] FL_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pipe_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             redirect_req;

    load_use_detect u_load_use_detect (
        .ex_mem_read_i (ex_mem_read_i),
        .ex_rd_i       (ex_rd_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_uses_rs1_i (id_uses_rs1_i),
        .id_uses_rs2_i (id_uses_rs2_i),
        .load_use_o    (load_use)
    );

    assign redirect_req         = ex_branch_taken_i || ex_jal_i || ex_jalr_i;
    assign pc_redirect_target_o = ex_target_i;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pc_enable_o     = 1'b1;
        if_id_enable_o  = 1'b1;
        id_ex_enable_o  = 1'b1;
        ex_mem_enable_o = 1'b1;
        mem_wb_enable_o = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        pc_redirect_o   = 1'b0;

        if (reset) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            state_d       = RUN;
            cnt_d         = '0;
        end else if (mem_stall_i) begin
            pc_enable_o     = 1'b0;
            if_id_enable_o  = 1'b0;
            id_ex_enable_o  = 1'b0;
            ex_mem_enable_o = 1'b0;
            mem_wb_enable_o = 1'b0;
        end else if (redirect_req) begin
            // Any pending load-use stall is dropped: the ID instruction is being squashed.
            pc_redirect_o = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = REDIRECT;
                cnt_d   = FL_INIT;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                REDIRECT: begin
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                LOAD_STALL: begin
                    pc_enable_o    = 1'b0;
                    if_id_enable_o = 1'b0;
                    id_ex_flush_o  = 1'b1;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = RUN;
                    if (load_use) begin
                        pc_enable_o    = 1'b0;
                        if_id_enable_o = 1'b0;
                        id_ex_flush_o  = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LOAD_STALL;
                            cnt_d   = LS_INIT;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [31:0] freeze_cnt_q;

    // Outside reset and freeze, a low PC enable can only come from a load-use stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (!mem_stall_i && !pc_enable_o) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (if_id_flush_o)                flush_cnt_q <= flush_cnt_q + 32'd1;
            if (mem_stall_i)                  freeze_cnt_q <= freeze_cnt_q + 32'd1;
        end
    end

    assign stall_count_o  = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;
    assign freeze_count_o = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed hazard scenarios then random traffic.
module tb_pipeline_hazard_controller;

    localparam int LSC = 3;
    localparam int FLC = 2;

    typedef struct packed {
        logic        rst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        mr;
        logic [4:0]  rd;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [31:0] tgt;
        logic        ms;
    } stim_t;

    typedef struct packed {
        logic [7:0]  ctl;
        logic [31:0] tgt;
        logic [31:0] c_stall;
        logic [31:0] c_flush;
        logic [31:0] c_freeze;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
    logic        id_uses_rs1_i = 1'b0, id_uses_rs2_i = 1'b0, ex_mem_read_i = 1'b0;
    logic        ex_branch_taken_i = 1'b0, ex_jal_i = 1'b0, ex_jalr_i = 1'b0, mem_stall_i = 1'b0;
    logic [31:0] ex_target_i = '0;
    logic        pc_enable_o, if_id_enable_o, id_ex_enable_o, ex_mem_enable_o, mem_wb_enable_o;
    logic        if_id_flush_o, id_ex_flush_o, pc_redirect_o;
    logic [31:0] pc_redirect_target_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count_o, flush_count_o, freeze_count_o;
`endif

    pipeline_hazard_controller #(
        .LOAD_STALL_CYCLES (LSC),
        .FLUSH_CYCLES      (FLC),
        .CNT_W             (3)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .id_rs1_i             (id_rs1_i),
        .id_rs2_i             (id_rs2_i),
        .id_uses_rs1_i        (id_uses_rs1_i),
        .id_uses_rs2_i        (id_uses_rs2_i),
        .ex_mem_read_i        (ex_mem_read_i),
        .ex_rd_i              (ex_rd_i),
        .ex_branch_taken_i    (ex_branch_taken_i),
        .ex_jal_i             (ex_jal_i),
        .ex_jalr_i            (ex_jalr_i),
        .ex_target_i          (ex_target_i),
        .mem_stall_i          (mem_stall_i),
        .pc_enable_o          (pc_enable_o),
        .if_id_enable_o       (if_id_enable_o),
        .id_ex_enable_o       (id_ex_enable_o),
        .ex_mem_enable_o      (ex_mem_enable_o),
        .mem_wb_enable_o      (mem_wb_enable_o),
        .if_id_flush_o        (if_id_flush_o),
        .id_ex_flush_o        (id_ex_flush_o),
        .pc_redirect_o        (pc_redirect_o),
        .pc_redirect_target_o (pc_redirect_target_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_count_o        (stall_count_o),
        .flush_count_o        (flush_count_o),
        .freeze_count_o       (freeze_count_o)
`endif
    );

    always #5 clk = ~clk;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    // Reference model: remaining forced cycles of each kind, plus event tallies.
    int          stall_rem = 0;
    int          flush_rem = 0;
    logic [31:0] m_stall = '0, m_flush = '0, m_freeze = '0;

    task automatic model(input stim_t s, output exp_t e);
        logic pc_en, ifid_en, others_en, ifid_fl, idex_fl, redir, lu, rq;
        e.tgt      = s.tgt;
        e.c_stall  = m_stall;
        e.c_flush  = m_flush;
        e.c_freeze = m_freeze;
        pc_en = 1; ifid_en = 1; others_en = 1; ifid_fl = 0; idex_fl = 0; redir = 0;
        lu = s.mr && (s.rd != 5'd0) &&
             ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));
        rq = s.br || s.jal || s.jalr;
        if (s.rst) begin
            ifid_fl = 1; idex_fl = 1;
            stall_rem = 0; flush_rem = 0;
            m_stall = '0; m_flush = '0; m_freeze = '0;
        end else if (s.ms) begin
            pc_en = 0; ifid_en = 0; others_en = 0;
            m_freeze++;
        end else if (rq) begin
            redir = 1; ifid_fl = 1; idex_fl = 1;
            flush_rem = FLC - 1; stall_rem = 0;
            m_flush++;
        end else if (flush_rem > 0) begin
            ifid_fl = 1; idex_fl = 1;
            flush_rem--;
            m_flush++;
        end else if (stall_rem > 0) begin
            pc_en = 0; ifid_en = 0; idex_fl = 1;
            stall_rem--;
            m_stall++;
        end else if (lu) begin
            pc_en = 0; ifid_en = 0; idex_fl = 1;
            stall_rem = LSC - 1;
            m_stall++;
        end
        e.ctl = {pc_en, ifid_en, others_en, others_en, others_en, ifid_fl, idex_fl, redir};
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        reset             = s.rst;
        id_rs1_i          = s.rs1;
        id_rs2_i          = s.rs2;
        id_uses_rs1_i     = s.u1;
        id_uses_rs2_i     = s.u2;
        ex_mem_read_i     = s.mr;
        ex_rd_i           = s.rd;
        ex_branch_taken_i = s.br;
        ex_jal_i          = s.jal;
        ex_jalr_i         = s.jalr;
        ex_target_i       = s.tgt;
        mem_stall_i       = s.ms;
        model(s, e);
        sb_q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.tgt = $urandom;
        return s;
    endfunction

    function automatic stim_t hazard();
        stim_t s;
        s = idle();
        s.mr = 1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1; s.rs2 = 5'd1;
        return s;
    endfunction

    // Monitor: outputs are combinational, so every scheduled cycle presents one response.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t        e;
            logic [7:0]  act;
            e   = sb_q.pop_front();
            act = {pc_enable_o, if_id_enable_o, id_ex_enable_o, ex_mem_enable_o,
                   mem_wb_enable_o, if_id_flush_o, id_ex_flush_o, pc_redirect_o};
            vectors++;
            if (act !== e.ctl || pc_redirect_target_o !== e.tgt) begin
                miscompares++;
                $display("FAIL ctl t=%0t actual ctl=%b tgt=%h expected ctl=%b tgt=%h",
                         $time, act, pc_redirect_target_o, e.ctl, e.tgt);
            end
`ifdef HAZARD_PERF_CNT_EN
            vectors++;
            if (stall_count_o !== e.c_stall || flush_count_o !== e.c_flush ||
                freeze_count_o !== e.c_freeze) begin
                miscompares++;
                $display("FAIL perf_cnt t=%0t actual %0d/%0d/%0d expected %0d/%0d/%0d",
                         $time, stall_count_o, flush_count_o, freeze_count_o,
                         e.c_stall, e.c_flush, e.c_freeze);
            end
`endif
        end
    end

    initial begin
        stim_t s;
        s = idle(); s.rst = 1;
        step(s); step(s);

        // lw x5 followed by a reader of x5
        step(hazard());
        repeat (4) step(idle());

        // rd = x0, and an rs2 match that is not actually read
        s = hazard(); s.rd = 5'd0; s.rs1 = 5'd0; step(s);
        s = hazard(); s.u1 = 0; s.rs1 = 5'd1; s.rs2 = 5'd5; s.u2 = 0; step(s);
        step(idle());

        // JAL to 0x40
        s = idle(); s.jal = 1; s.tgt = 32'h40; step(s);
        repeat (3) step(idle());

        // taken branch together with a load-use hazard
        s = hazard(); s.br = 1; s.tgt = 32'h80; step(s);
        repeat (3) step(idle());

        // memory freeze in the middle of a multi-cycle load stall
        step(hazard());
        s = idle(); s.ms = 1;
        repeat (3) step(s);
        repeat (4) step(idle());

        // reset during the post-redirect flush window
        s = idle(); s.jalr = 1; step(s);
        s = idle(); s.rst = 1; step(s);
        repeat (2) step(idle());

        for (int i = 0; i < 4000; i++) begin
            s.rst  = ($urandom_range(0, 63) == 0);
            s.rs1  = 5'($urandom_range(0, 3));
            s.rs2  = 5'($urandom_range(0, 3));
            s.u1   = 1'($urandom);
            s.u2   = 1'($urandom);
            s.mr   = 1'($urandom);
            s.rd   = 5'($urandom_range(0, 3));
            s.br   = ($urandom_range(0, 15) == 0);
            s.jal  = ($urandom_range(0, 23) == 0);
            s.jalr = ($urandom_range(0, 23) == 0);
            s.tgt  = $urandom;
            s.ms   = ($urandom_range(0, 7) == 0);
            step(s);
        end

        repeat (3) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain actual pending=%0d expected pending=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Generates per-stage enable/flush strobes and the PC redirect command. Sources:
  - load-use hazards detected between ID and EX;
  - taken branch/JAL/JALR resolved in EX;
  - data-memory busy freeze.
- Replaces the hard-tied `enable=1` on pipeline registers and the ungated PC next-value mux select.

Parameters:
- `LOAD_STALL_CYCLES`, 1: bubbles inserted per load-use hazard (1..7).
- `FLUSH_CYCLES`, 1: cycles IF/ID stays flushed after a redirect, for fetch latency (1..7).
- `CNT_W`, 3: width of the internal stall/flush down-counter. Must hold max(`LOAD_STALL_CYCLES`, `FLUSH_CYCLES`).

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `id_rs1_i` in 5: rs1 field of instruction in ID.
- `id_rs2_i` in 5: rs2 field of instruction in ID.
- `id_uses_rs1_i` in 1: ID instruction reads rs1.
- `id_uses_rs2_i` in 1: ID instruction reads rs2.
- `ex_mem_read_i` in 1: instruction in EX is a load.
- `ex_rd_i` in 5: destination register of EX instruction.
- `ex_branch_taken_i` in 1: EX branch condition true AND `Branch` set.
- `ex_jal_i` in 1: EX instruction is JAL.
- `ex_jalr_i` in 1: EX instruction is JALR.
- `ex_target_i` in 32: resolved EX target (PC+imm or ALU result for JALR).
- `mem_stall_i` in 1: data memory not ready; freeze whole pipeline.
- `pc_enable_o` out 1: PC register load enable.
- `if_id_enable_o` out 1: IF/ID enable.
- `id_ex_enable_o` out 1: ID/EX enable.
- `ex_mem_enable_o` out 1: EX/MEM enable.
- `mem_wb_enable_o` out 1: MEM/WB enable.
- `if_id_flush_o` out 1: IF/ID loads NOP (0x00000013) on next edge.
- `id_ex_flush_o` out 1: ID/EX loads bubble (all controls 0) on next edge.
- `pc_redirect_o` out 1: PC loads `pc_redirect_target_o` instead of PC+4.
- `pc_redirect_target_o` out 32: redirect address.

Behaviour:
- FSM states: `RUN`, `LOAD_STALL`, `REDIRECT`. All outputs are combinational from state and inputs.
- Definitions:
  - `redirect_req` = `ex_branch_taken_i` | `ex_jal_i` | `ex_jalr_i`.
  - `load_use` = `ex_mem_read_i` & (`ex_rd_i` != 0) & ((`id_uses_rs1_i` & `id_rs1_i` == `ex_rd_i`) | (`id_uses_rs2_i` & `id_rs2_i` == `ex_rd_i`)).
- Default (`RUN`, no event):
  - all enables = 1;
  - flushes = 0;
  - `pc_redirect_o` = 0;
  - `pc_redirect_target_o` = `ex_target_i` (always passed through).
- Priority, evaluated in every state: reset > `mem_stall_i` > `redirect_req` > state continuation > `load_use`.
- `mem_stall_i`=1:
  - all five enables = 0;
  - flushes = 0;
  - redirect = 0;
  - state and counter hold.
- `redirect_req` (accepted when `mem_stall_i`=0, any state):
  - `pc_redirect_o`=1;
  - `if_id_flush_o`=1 and `id_ex_flush_o`=1;
  - all enables = 1.
  - If `FLUSH_CYCLES`>1: next state is `REDIRECT` with counter = `FLUSH_CYCLES`-1. Otherwise next state is `RUN`.
  - A concurrent `load_use` is ignored, because the ID instruction is squashed.
- `REDIRECT`:
  - `if_id_flush_o`=1, `id_ex_flush_o`=1, enables = 1, `pc_redirect_o`=0.
  - Counter decrements; at counter==1 the next state is `RUN`.
- `load_use` in `RUN`:
  - `pc_enable_o`=0 and `if_id_enable_o`=0;
  - `id_ex_flush_o`=1;
  - other enables = 1.
  - If `LOAD_STALL_CYCLES`>1: next state is `LOAD_STALL` with counter = `LOAD_STALL_CYCLES`-1.
- `LOAD_STALL`:
  - same outputs as the `load_use` cycle, without re-evaluating `load_use`.
  - Counter decrements; at counter==1 the next state is `RUN`.
- `load_use` is re-evaluated in `RUN` after a stall, so a back-to-back hazard from a new load stalls again.
- Rd=x0 never causes a stall.
- Reset (synchronous):
  - state → `RUN`, counter → 0.
  - While `reset`=1: enables = 1, both flushes = 1, `pc_redirect_o`=0.
- Latency: hazard response takes effect at the next clock edge (0-cycle combinational decision); redirect penalty is `FLUSH_CYCLES`+1 bubbles.

Optional Feature:
- Macro: `HAZARD_PERF_CNT_EN`.
- Defined:
  - adds outputs `stall_count_o` [31:0], `flush_count_o` [31:0] and `freeze_count_o` [31:0];
  - each increments once per cycle in which `pc_enable_o`=0 by load-use, `if_id_flush_o`=1 by redirect/`REDIRECT`, or `mem_stall_i`=1 respectively;
  - counters wrap at 2^32 and clear to 0 on reset.
- Undefined: ports and counters are absent; core behaviour is identical.

Decomposition:
- Package `riscv_pipe_ctrl_pkg`:
  - state enum (`RUN`=2'd0, `LOAD_STALL`=2'd1, `REDIRECT`=2'd2);
  - `NOP_INSTR`=32'h00000013;
  - `REG_X0`=5'd0.
- One sub-module `load_use_detect`: purely combinational register-compare producing `load_use`. It is reused later by the forwarding unit for its rd≠x0 checks.

Test Plan:
- lw x5 in EX (`ex_mem_read_i`=1, `ex_rd_i`=5) with ID add x6,x5,x1 (`id_rs1_i`=5, `id_uses_rs1_i`=1) → exactly 1 cycle of `pc_enable_o`=0, `if_id_enable_o`=0, `id_ex_flush_o`=1, then `RUN`.
- Same load with `ex_rd_i`=0, or with `id_uses_rs2_i`=0 and `id_rs2_i`=5 → no stall.
- `ex_jal_i`=1, `ex_target_i`=0x40, `FLUSH_CYCLES`=2 → cycle 0: `pc_redirect_o`=1, target 0x40, both flushes; cycle 1: flushes only; cycle 2: `RUN`.
- `ex_branch_taken_i`=1 together with `load_use`=1 → redirect wins: no PC stall, `pc_redirect_o`=1.
- `mem_stall_i`=1 for 3 cycles during `LOAD_STALL` (`LOAD_STALL_CYCLES`=3, counter=2) → all enables 0 for 3 cycles, counter held at 2; then 2 more stall cycles follow.
- `reset` asserted mid-`REDIRECT` → next cycle state `RUN`; with `HAZARD_PERF_CNT_EN` defined, all counters read 0.
